unified_mem_arbiter: RTL

// - Shares one single-port unified memory between instruction fetch (I) and load/store (D) requesters.
// - Lets the RISC-V core run from one program/data RAM image, as needed for a multicycle or stalling core.
// - Sits between the core's fetch/LSU interfaces and the memory macro.
// - Request/grant handshake in, fixed-latency response out; one outstanding access at a time.

---
 rtl/unified_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and load/store (D) requesters.
// One outstanding access at a time: grant in IDLE, fixed-latency response out of WAIT.
module unified_mem_arbiter #(
  parameter int unsigned AW              = 12,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned RR_MODE         = 0,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          m_en,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam int unsigned SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [1:0]    LatInit   = 2'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_DATA_STREAK);

  logic [0:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          last_owner_q, last_owner_d;
  logic          owner_q, owner_d;
  logic          store_q, store_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          sel_data;
  logic          grant_any;
  logic          done;
  logic [31:0]   d_resp;

  // Winner selection; only meaningful when at least one request is present.
  always_comb begin
    if (!i_req) begin
      sel_data = 1'b1;
    end else if (!d_req) begin
      sel_data = 1'b0;
    end else if (RR_MODE != 0) begin
      sel_data = ~last_owner_q;
    end else begin
      sel_data = (streak_q != StreakMax);
    end
  end

  // Reset (active low) masks grants and responses combinationally so an abort is clean.
  assign grant_any = reset && (state_q == StIdle) && (i_req || d_req);
  assign done      = reset && (state_q == StWait) && (cnt_q == 2'd0);
  assign d_resp    = store_q ? 32'd0 : m_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    store_d      = store_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    if (grant_any) begin
      state_d      = StWait;
      cnt_d        = LatInit;
      owner_d      = sel_data;
      last_owner_d = sel_data;
      store_d      = sel_data && d_we;
      // The streak only counts D wins that actually made I wait.
      if (sel_data && i_req) begin
        streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end else if (state_q == StWait) begin
      if (cnt_q == 2'd0) begin
        state_d = StIdle;
        if (owner_q) begin
          d_rdata_d = d_resp;
        end else begin
          i_rdata_d = m_rdata;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      streak_q     <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      store_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_gnt    = grant_any && !sel_data;
  assign d_gnt    = grant_any && sel_data;
  assign m_en     = grant_any;
  assign m_addr   = !grant_any ? '0 : (sel_data ? d_addr : i_addr);
  assign m_we     = (d_gnt && d_we) ? d_wstrb : 4'b0000;
  assign m_wdata  = (d_gnt && d_we) ? d_wdata : 32'd0;
  assign i_rvalid = done && !owner_q;
  assign d_rvalid = done && owner_q;
  // Response data is visible in the rvalid cycle and held afterwards.
  assign i_rdata  = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata  = d_rvalid ? d_resp : d_rdata_q;
  assign busy     = (state_q == StWait);
  assign owner    = owner_q;

endmodule
